n_clic_nested: RTL and testbench
================================

# n_clic_nested

Registered, nesting-aware interrupt arbiter for the hippo core, parametrised in line count, priority width and nesting depth. It latches per-line pending state, picks the highest-priority enabled pending line that exceeds the currently running priority, and presents it to the core. It tracks the running priority across nested handlers with an internal threshold stack driven by the core's acknowledge and return strobes.

## Interface
- `INT_AMOUNT`, 8, number of interrupt lines; ≥2.
- `PRIO_WIDTH`, 2, priority bits per line; priority 0 means "never interrupts".
- `NEST_DEPTH`, 4, maximum number of simultaneously active (nested) handlers; ≥1.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_irq`  in  INT_AMOUNT  raw interrupt request lines.
- `i_enables`  in  INT_AMOUNT  per-line enable.
- `i_priorities`  in  INT_AMOUNT*PRIO_WIDTH  packed priorities; line k uses bits [k*PRIO_WIDTH +: PRIO_WIDTH].
- `i_global_ie`  in  1  global interrupt enable; gates `o_int` only.
- `i_ack`  in  1  core takes the presented interrupt.
- `i_ret`  in  1  core returns from the current handler.
- `o_int`  out  1  interrupt request to the core (registered).
- `o_idx`  out  $clog2(INT_AMOUNT)  index of the presented line (registered).
- `o_prio`  out  PRIO_WIDTH  priority of the presented line (registered).
- `o_level`  out  PRIO_WIDTH  current running priority (threshold).
- `o_depth`  out  $clog2(NEST_DEPTH+1)  number of active handlers.
- `o_ret_err`  out  1  one-cycle pulse on `i_ret` when `o_depth`==0.

## Operation
- Pending: `pend[k]` sets on an edge of `i_irq[k]` (see Configuration). It clears when an ack is accepted for line k. If set and clear coincide on the same line, set wins.
- Candidate: `pend[k] & i_enables[k] & (prio[k] > threshold)`. Comparison is unsigned. Priority 0 never qualifies.
- Winner: the highest priority among candidates. Ties go to the lowest index.
- Requests are suppressed when `o_depth`==NEST_DEPTH.
- `o_int` is `i_global_ie & winner_valid`, registered.
- `o_idx` and `o_prio` are registered from the winner. When there is no winner they hold 0.
- Ack is accepted only when `i_ack & o_int`. An `i_ack` while `o_int`=0 is ignored.
  - Push `threshold` onto the stack.
  - `threshold` ← `o_prio`; depth++.
  - Clear `pend[o_idx]`.
- Ret with depth>0: `threshold` ← stack top (pop); depth--.
- Ret with depth==0: no state change; `o_ret_err` pulses.
- Accepted ack and ret in the same cycle (tail-chain):
  - depth and stack contents are unchanged.
  - `threshold` ← `o_prio`.
  - `pend[o_idx]` clears.
- The stack is a NEST_DEPTH×PRIO_WIDTH register file indexed by depth. Stack entries are not cleared on pop.

## Timing
- Reset (async assert, sync release): `o_int`=0, `o_idx`=0, `o_prio`=0, `o_level`=0, `o_depth`=0, `o_ret_err`=0. Also cleared: `pend`, stack, and the `i_irq` sample register.
- Edge mode latency:
  - Line `k` rises before edge e0 → `pend[k]` set at e0.
  - `o_int` is valid after e1.
- Level mode latency: `o_int` is valid one edge after `i_irq` rises.
- Ack accepted in cycle t:
  - `o_int` is forced 0 in cycle t+1. This blanks the stale registered output.
  - Re-arbitration against the new threshold is visible from t+2.
- `o_level` and `o_depth` update on the edge ending the ack/ret cycle.
- Priority, enable and `i_global_ie` changes take effect on the next edge. Nothing already presented is revoked combinationally.
- Reset asserted mid-handler discards the whole nesting context immediately.

## Configuration
- `N_CLIC_EDGE_EN` defined (edge mode):
  - `pend[k]` sets on the rising edge of `i_irq[k]`, detected against a one-cycle sample register that resets to 0.
  - A line held high across reset release pends exactly once.
  - `pend[k]` is cleared by ack.
- `N_CLIC_EDGE_EN` undefined (level mode):
  - `pend[k]` is `i_irq[k]` directly; there is no pending storage.
  - Ack does not clear it. The source must drop the line.

## Test plan
- Priorities {1,3,2,3,...}, all enabled, lines 1 and 3 raised together → `o_int`=1, `o_idx`=1, `o_prio`=3 (tie goes to the lower index).
- Nesting:
  - Ack line 2 (prio 2) → `o_level`=2, `o_depth`=1.
  - Raise line 0 (prio 1) → no `o_int`.
  - Raise line 1 (prio 3) → `o_int`, `o_idx`=1.
  - Ack → `o_level`=3, `o_depth`=2.
  - Two rets → `o_level` 2 then 0.
- NEST_DEPTH=2, two nested acks, third higher-priority line pending → `o_int` stays 0 until a ret; `o_int` then asserts 2 cycles after the ret.
- Tail-chain: in handler prio 2 with line 5 (prio 3) presented, `i_ack`=`i_ret`=1 → `o_depth` unchanged, `o_level`=3, `pend[5]` cleared.
- `i_ret` at depth 0 → `o_ret_err` pulses for exactly 1 cycle; no other state changes.
- Edge mode:
  - Re-pulse line 4 in the ack cycle → remains pending and is re-presented after the ret.
  - Assert reset mid-handler → all outputs 0 and `o_depth`=0.

Source files
------------

// File: rtl/n_clic_nested_if.sv
// Signal bundle between the n_clic_nested interrupt arbiter (slave) and the core (master).
interface n_clic_nested_if #(
   parameter int INT_AMOUNT = 8,
   parameter int PRIO_WIDTH = 2,
   parameter int NEST_DEPTH = 4
);
   localparam int IW = $clog2(INT_AMOUNT);
   localparam int DW = $clog2(NEST_DEPTH + 1);

   logic [INT_AMOUNT-1:0]            i_irq;
   logic [INT_AMOUNT-1:0]            i_enables;
   logic [INT_AMOUNT*PRIO_WIDTH-1:0] i_priorities;
   logic                             i_global_ie;
   logic                             i_ack;
   logic                             i_ret;
   logic                             o_int;
   logic [IW-1:0]                    o_idx;
   logic [PRIO_WIDTH-1:0]            o_prio;
   logic [PRIO_WIDTH-1:0]            o_level;
   logic [DW-1:0]                    o_depth;
   logic                             o_ret_err;

   modport slave (
      input  i_irq, i_enables, i_priorities, i_global_ie, i_ack, i_ret,
      output o_int, o_idx, o_prio, o_level, o_depth, o_ret_err
   );

   modport master (
      output i_irq, i_enables, i_priorities, i_global_ie, i_ack, i_ret,
      input  o_int, o_idx, o_prio, o_level, o_depth, o_ret_err
   );
endinterface

// File: rtl/n_clic_nested.sv
// Nesting-aware registered interrupt arbiter with a running-priority threshold stack.
// Define N_CLIC_EDGE_EN for edge-latched pending bits; default is level-sensitive lines.
module n_clic_nested #(
   parameter int INT_AMOUNT = 8,
   parameter int PRIO_WIDTH = 2,
   parameter int NEST_DEPTH = 4
) (
   input logic            i_clk,
   input logic            i_rst_n,
   n_clic_nested_if.slave bus
);
   localparam int IW = $clog2(INT_AMOUNT);
   localparam int DW = $clog2(NEST_DEPTH + 1);
   localparam int SW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

   logic [INT_AMOUNT-1:0] pend;
   logic                  int_q;
   logic [IW-1:0]         idx_q;
   logic [PRIO_WIDTH-1:0] prio_q;
   logic [PRIO_WIDTH-1:0] threshold;
   logic [DW-1:0]         depth;
   logic                  ret_err_q;
   logic [PRIO_WIDTH-1:0] stack [NEST_DEPTH];

   logic                  ack_acc;
   logic                  full;
   logic [SW-1:0]         push_ptr;
   logic [SW-1:0]         pop_ptr;
   logic                  win_valid;
   logic [IW-1:0]         win_idx;
   logic [PRIO_WIDTH-1:0] win_prio;

   // ack only counts against what is actually being presented
   assign ack_acc  = bus.i_ack & int_q;
   assign full     = (depth == DW'(NEST_DEPTH));
   assign push_ptr = SW'(depth);
   assign pop_ptr  = SW'(depth - 1'b1);

`ifdef N_CLIC_EDGE_EN
   logic [INT_AMOUNT-1:0] irq_q;
   logic [INT_AMOUNT-1:0] pend_q;
   logic [INT_AMOUNT-1:0] pend_clr;

   always_comb begin
      pend_clr = '0;
      if (ack_acc) pend_clr[idx_q] = 1'b1;
   end

   // a fresh edge in the ack cycle overrides the clear so it is not lost
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         irq_q  <= '0;
         pend_q <= '0;
      end else begin
         irq_q  <= bus.i_irq;
         pend_q <= (pend_q & ~pend_clr) | (bus.i_irq & ~irq_q);
      end
   end

   assign pend = pend_q;
`else
   assign pend = bus.i_irq;
`endif

   // strict compare keeps the lowest index on ties and rejects priority 0
   always_comb begin
      logic [PRIO_WIDTH-1:0] p;
      p         = '0;
      win_valid = 1'b0;
      win_idx   = '0;
      win_prio  = '0;
      for (int k = 0; k < INT_AMOUNT; k++) begin
         p = bus.i_priorities[k*PRIO_WIDTH +: PRIO_WIDTH];
         if (!full && pend[k] && bus.i_enables[k] && (p > threshold) && (p > win_prio)) begin
            win_valid = 1'b1;
            win_idx   = IW'(k);
            win_prio  = p;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         int_q     <= 1'b0;
         idx_q     <= '0;
         prio_q    <= '0;
         threshold <= '0;
         depth     <= '0;
         ret_err_q <= 1'b0;
         for (int i = 0; i < NEST_DEPTH; i++) stack[i] <= '0;
      end else begin
         // the cycle after an ack still carries the stale winner, so blank it
         int_q     <= bus.i_global_ie & win_valid & ~ack_acc;
         idx_q     <= win_idx;
         prio_q    <= win_prio;
         ret_err_q <= bus.i_ret & ~ack_acc & (depth == '0);
         if (ack_acc && bus.i_ret) begin
            threshold <= prio_q;
         end else if (ack_acc) begin
            stack[push_ptr] <= threshold;
            threshold       <= prio_q;
            depth           <= depth + 1'b1;
         end else if (bus.i_ret && (depth != '0)) begin
            threshold <= stack[pop_ptr];
            depth     <= depth - 1'b1;
         end
      end
   end

   assign bus.o_int     = int_q;
   assign bus.o_idx     = idx_q;
   assign bus.o_prio    = prio_q;
   assign bus.o_level   = threshold;
   assign bus.o_depth   = depth;
   assign bus.o_ret_err = ret_err_q;
endmodule

// File: tb/tb_n_clic_nested.sv
// Bench for n_clic_nested: directed vector table plus randomized run against a behavioural model.
module tb_n_clic_nested;
   localparam int NI = 8;
   localparam int PW = 2;
   localparam int ND = 2;
   localparam logic [15:0] PRIO_FIX = 16'h1EED; // lines 0..7: 1,3,2,3,2,3,1,0

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   n_clic_nested_if #(.INT_AMOUNT(NI), .PRIO_WIDTH(PW), .NEST_DEPTH(ND)) bus ();

   n_clic_nested #(.INT_AMOUNT(NI), .PRIO_WIDTH(PW), .NEST_DEPTH(ND)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] irq;
      logic [7:0] en;
      logic       gie;
      logic       ack;
      logic       ret;
      logic       e_int;
      int         e_idx;
      int         e_prio;
      int         e_lvl;
      int         e_dep;
      logic       e_err;
      logic       chk_sel;
   } vec_t;

   vec_t vq[$];

   // reference model state
   int  m_thr;
   int  m_stk[$];
   bit  m_int;
   bit  m_found;
   bit  m_err;
   int  m_idx;
   int  m_prio;
`ifdef N_CLIC_EDGE_EN
   logic [NI-1:0] m_pend;
   logic [NI-1:0] m_irq_prev;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lp(input int k);
      logic [15:0] pv;
      pv = bus.i_priorities;
      return int'(pv[k*PW +: PW]);
   endfunction

   task automatic model_reset();
      m_thr   = 0;
      m_stk   = {};
      m_int   = 1'b0;
      m_found = 1'b0;
      m_err   = 1'b0;
      m_idx   = 0;
      m_prio  = 0;
`ifdef N_CLIC_EDGE_EN
      m_pend     = '0;
      m_irq_prev = '0;
`endif
   endtask

   task automatic model_step();
      logic [NI-1:0] pv;
      bit ack_ok;
      int top;
      int new_idx;
`ifdef N_CLIC_EDGE_EN
      pv = m_pend;
`else
      pv = bus.i_irq;
`endif
      ack_ok  = bus.i_ack && m_int;
      top     = 0;
      new_idx = 0;
      if (m_stk.size() < ND) begin
         for (int k = 0; k < NI; k++)
            if (pv[k] && bus.i_enables[k] && lp(k) > m_thr && lp(k) > top) top = lp(k);
      end
      if (top > 0) begin
         for (int k = NI - 1; k >= 0; k--)
            if (pv[k] && bus.i_enables[k] && lp(k) == top) new_idx = k;
      end
      m_found = (top > 0);
      m_err   = bus.i_ret && !ack_ok && (m_stk.size() == 0);
      if (ack_ok && bus.i_ret) m_thr = m_prio;
      else if (ack_ok) begin
         m_stk.push_back(m_thr);
         m_thr = m_prio;
      end else if (bus.i_ret && m_stk.size() > 0) m_thr = m_stk.pop_back();
`ifdef N_CLIC_EDGE_EN
      if (ack_ok) m_pend[m_idx] = 1'b0;
      m_pend     = m_pend | (bus.i_irq & ~m_irq_prev);
      m_irq_prev = bus.i_irq;
`endif
      m_int  = bus.i_global_ie && m_found && !ack_ok;
      m_idx  = new_idx;
      m_prio = top;
   endtask

   task automatic check_model();
      chk("model_int", 32'(bus.o_int), 32'(m_int));
      chk("model_level", 32'(bus.o_level), 32'(m_thr));
      chk("model_depth", 32'(bus.o_depth), 32'(m_stk.size()));
      chk("model_ret_err", 32'(bus.o_ret_err), 32'(m_err));
      if (m_int || !m_found) begin
         chk("model_idx", 32'(bus.o_idx), 32'(m_idx));
         chk("model_prio", 32'(bus.o_prio), 32'(m_prio));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic do_reset();
      bus.i_irq        = '0;
      bus.i_enables    = '0;
      bus.i_priorities = PRIO_FIX;
      bus.i_global_ie  = 1'b0;
      bus.i_ack        = 1'b0;
      bus.i_ret        = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_int", 32'(bus.o_int), 32'd0);
      chk("rst_idx", 32'(bus.o_idx), 32'd0);
      chk("rst_prio", 32'(bus.o_prio), 32'd0);
      chk("rst_level", 32'(bus.o_level), 32'd0);
      chk("rst_depth", 32'(bus.o_depth), 32'd0);
      chk("rst_ret_err", 32'(bus.o_ret_err), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic add(input logic [7:0] irq, input logic [7:0] en, input logic gie,
                      input logic ack, input logic ret, input logic e_int, input int e_idx,
                      input int e_prio, input int e_lvl, input int e_dep, input logic e_err,
                      input logic chk_sel);
      vec_t v;
      v.irq = irq; v.en = en; v.gie = gie; v.ack = ack; v.ret = ret;
      v.e_int = e_int; v.e_idx = e_idx; v.e_prio = e_prio; v.e_lvl = e_lvl;
      v.e_dep = e_dep; v.e_err = e_err; v.chk_sel = chk_sel;
      vq.push_back(v);
   endtask

   initial begin
      //   irq    en     gie ack ret  int idx pri lvl dep err sel
      add(8'h00, 8'hFF, 1, 0, 0,    0,  0,  0,  0,  0,  0,  1);
      add(8'h0A, 8'hFF, 1, 0, 0,    1,  1,  3,  0,  0,  0,  1); // tie -> lower index
      add(8'h00, 8'hFF, 1, 0, 0,    0,  0,  0,  0,  0,  0,  1);
      add(8'h04, 8'hFF, 1, 0, 0,    1,  2,  2,  0,  0,  0,  1);
      add(8'h04, 8'hFF, 1, 1, 0,    0,  0,  0,  2,  1,  0,  0);
      add(8'h05, 8'hFF, 1, 0, 0,    0,  0,  0,  2,  1,  0,  1);
      add(8'h07, 8'hFF, 1, 0, 0,    1,  1,  3,  2,  1,  0,  1);
      add(8'h07, 8'hFF, 1, 1, 0,    0,  0,  0,  3,  2,  0,  0);
      add(8'h07, 8'hFF, 1, 0, 1,    0,  0,  0,  2,  1,  0,  1);
      add(8'h00, 8'hFF, 1, 0, 1,    0,  0,  0,  0,  0,  0,  1);
      add(8'h00, 8'hFF, 1, 0, 1,    0,  0,  0,  0,  0,  1,  1); // ret at depth 0
      add(8'h00, 8'hFF, 1, 0, 0,    0,  0,  0,  0,  0,  0,  1);
      add(8'h04, 8'hFF, 1, 0, 0,    1,  2,  2,  0,  0,  0,  1);
      add(8'h04, 8'hFF, 1, 1, 0,    0,  0,  0,  2,  1,  0,  0);
      add(8'h24, 8'hFF, 1, 0, 0,    1,  5,  3,  2,  1,  0,  1);
      add(8'h24, 8'hFF, 1, 1, 1,    0,  0,  0,  3,  1,  0,  0); // tail-chain
      add(8'h04, 8'hFF, 1, 0, 0,    0,  0,  0,  3,  1,  0,  1);
      add(8'h00, 8'hFF, 1, 0, 1,    0,  0,  0,  0,  0,  0,  1);
      add(8'h08, 8'hFF, 0, 0, 0,    0,  0,  0,  0,  0,  0,  0);
      add(8'h08, 8'hFF, 1, 0, 0,    1,  3,  3,  0,  0,  0,  1);
      add(8'h08, 8'hF7, 1, 0, 0,    0,  0,  0,  0,  0,  0,  1);
      add(8'h80, 8'hFF, 1, 0, 0,    0,  0,  0,  0,  0,  0,  1); // priority 0
      add(8'hC0, 8'hFF, 1, 0, 0,    1,  6,  1,  0,  0,  0,  1);
      add(8'h00, 8'hFF, 1, 0, 0,    0,  0,  0,  0,  0,  0,  1);
      add(8'h01, 8'hFF, 1, 0, 0,    1,  0,  1,  0,  0,  0,  1);
      add(8'h01, 8'hFF, 1, 1, 0,    0,  0,  0,  1,  1,  0,  0);
      add(8'h05, 8'hFF, 1, 0, 0,    1,  2,  2,  1,  1,  0,  1);
      add(8'h05, 8'hFF, 1, 1, 0,    0,  0,  0,  2,  2,  0,  0);
      add(8'h07, 8'hFF, 1, 0, 0,    0,  0,  0,  2,  2,  0,  1); // nest full
      add(8'h07, 8'hFF, 1, 0, 0,    0,  0,  0,  2,  2,  0,  1);
      add(8'h07, 8'hFF, 1, 0, 1,    0,  0,  0,  1,  1,  0,  1);
      add(8'h07, 8'hFF, 1, 0, 0,    1,  1,  3,  1,  1,  0,  1); // 2 cycles after ret
      add(8'h00, 8'hFF, 1, 0, 1,    0,  0,  0,  0,  0,  0,  1);
      add(8'h00, 8'hFF, 1, 1, 0,    0,  0,  0,  0,  0,  0,  1); // ack ignored

      do_reset();

`ifndef N_CLIC_EDGE_EN
      for (int i = 0; i < vq.size(); i++) begin
         bus.i_irq       = vq[i].irq;
         bus.i_enables   = vq[i].en;
         bus.i_global_ie = vq[i].gie;
         bus.i_ack       = vq[i].ack;
         bus.i_ret       = vq[i].ret;
         cycle();
         chk($sformatf("row%0d_int", i), 32'(bus.o_int), 32'(vq[i].e_int));
         chk($sformatf("row%0d_level", i), 32'(bus.o_level), 32'(vq[i].e_lvl));
         chk($sformatf("row%0d_depth", i), 32'(bus.o_depth), 32'(vq[i].e_dep));
         chk($sformatf("row%0d_ret_err", i), 32'(bus.o_ret_err), 32'(vq[i].e_err));
         if (vq[i].chk_sel) begin
            chk($sformatf("row%0d_idx", i), 32'(bus.o_idx), 32'(vq[i].e_idx));
            chk($sformatf("row%0d_prio", i), 32'(bus.o_prio), 32'(vq[i].e_prio));
         end
      end
`else
      // line 4 re-pulsed during its own ack stays pending and returns after the ret
      bus.i_enables   = 8'hFF;
      bus.i_global_ie = 1'b1;
      bus.i_irq = 8'h10; cycle();
      bus.i_irq = 8'h00; cycle();
      chk("edge_first_int", 32'(bus.o_int), 32'd1);
      chk("edge_first_idx", 32'(bus.o_idx), 32'd4);
      bus.i_irq = 8'h10; bus.i_ack = 1'b1; cycle();
      chk("edge_ack_depth", 32'(bus.o_depth), 32'd1);
      bus.i_irq = 8'h00; bus.i_ack = 1'b0; cycle();
      chk("edge_masked_int", 32'(bus.o_int), 32'd0);
      bus.i_ret = 1'b1; cycle();
      chk("edge_ret_depth", 32'(bus.o_depth), 32'd0);
      bus.i_ret = 1'b0; cycle();
      chk("edge_repend_int", 32'(bus.o_int), 32'd1);
      chk("edge_repend_idx", 32'(bus.o_idx), 32'd4);
      cycle();
`endif

      // reset in the middle of a handler
      do_reset();
      bus.i_enables   = 8'hFF;
      bus.i_global_ie = 1'b1;
      bus.i_irq       = 8'h04;
      repeat (3) cycle();
      chk("mid_pre_int", 32'(bus.o_int), 32'd1);
      bus.i_ack = 1'b1; cycle();
      bus.i_ack = 1'b0;
      chk("mid_depth", 32'(bus.o_depth), 32'd1);
      chk("mid_level", 32'(bus.o_level), 32'd2);
      do_reset();

      // randomized run against the model
      bus.i_enables   = 8'hFF;
      bus.i_global_ie = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset();
            bus.i_enables = 8'hFF;
         end
         if ($urandom_range(0, 3) == 0) bus.i_irq = 8'($urandom);
         if ($urandom_range(0, 15) == 0) bus.i_enables = 8'($urandom | $urandom);
         if ($urandom_range(0, 31) == 0) bus.i_priorities = 16'($urandom);
         bus.i_global_ie = ($urandom_range(0, 7) != 0);
         bus.i_ack       = ($urandom_range(0, 2) == 0);
         bus.i_ret       = ($urandom_range(0, 5) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
